// File: rtl/mem_burst_pkg.sv
// Shared types and constants for the memory burst reader and its output FIFO.
package mem_burst_pkg;

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned OCC_W      = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_FINISH
  } state_e;

endpackage

// File: rtl/mem_burst_fifo2.sv
// Two-entry synchronous FIFO. Flush has priority over push/pop.
module mem_burst_fifo2
  import mem_burst_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [OCC_W-1:0]  occupancy_o,
  output logic [DATA_W-1:0] head_o
);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [OCC_W-1:0]  count_q;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop_i & (count_q != '0);
  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_push = push_i & ((count_q != OCC_W'(FIFO_DEPTH)) | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + OCC_W'(do_push) - OCC_W'(do_pop);
    end
  end

  assign full_o      = (count_q == OCC_W'(FIFO_DEPTH));
  assign empty_o     = (count_q == '0);
  assign occupancy_o = count_q;
  assign head_o      = mem_q[rd_ptr_q];

endmodule

// File: rtl/mem_burst_reader.sv
// Length-bounded burst reader: single-port memory (1-cycle latency) to valid/ready stream.
// Optional MEM_BURST_STRIDE_EN enables the programmable address stride (else stride is 1).
module mem_burst_reader
  import mem_burst_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] stride,
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  input  logic              ready,
  output logic              last
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [LEN_W-1:0]  beats_left_q, beats_left_d;
  logic              inflight_q;
  logic              busy_q;
  logic              done_q;

  logic              mem_en_c;
  logic              pop_c;
  logic              space_ok_c;
  logic              abort_hit_c;
  logic              flush_c;
  logic              push_c;
  logic [ADDR_W-1:0] step_c;

  logic              fifo_full;
  logic              fifo_empty;
  logic [OCC_W-1:0]  fifo_occ;
  logic [DATA_W-1:0] fifo_head;

`ifdef MEM_BURST_STRIDE_EN
  logic [ADDR_W-1:0] stride_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stride_q <= '0;
    end else if (start && (state_q == ST_IDLE)) begin
      stride_q <= stride;
    end
  end

  assign step_c = stride_q;
`else
  logic unused_stride;
  assign unused_stride = ^stride;
  assign step_c        = ADDR_W'(1);
`endif

  assign pop_c       = ~fifo_empty & ready;
  assign abort_hit_c = abort & ((state_q == ST_FETCH) | (state_q == ST_DRAIN));
  // Issue only if the word still has a FIFO slot once in-flight data lands.
  assign space_ok_c  = ({1'b0, fifo_occ} + 3'(inflight_q)) < (3'd2 + 3'(pop_c));
  assign mem_en_c    = (state_q == ST_FETCH) & (remaining_q != '0) & ~abort & space_ok_c;
  assign flush_c     = abort_hit_c;
  assign push_c      = inflight_q & ~abort_hit_c;

  // Next-state, address and counter logic
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    beats_left_d = beats_left_q;

    if (pop_c) begin
      beats_left_d = beats_left_q - LEN_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d       = start_addr;
          remaining_d  = len;
          beats_left_d = len;
          state_d      = (len == '0) ? ST_FINISH : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (mem_en_c) begin
          addr_d      = addr_q + step_c;
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if ((beats_left_q == '0) || ((beats_left_q == LEN_W'(1)) && pop_c)) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort_hit_c) begin
      state_d      = ST_FINISH;
      remaining_d  = '0;
      beats_left_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      remaining_q  <= '0;
      beats_left_q <= '0;
      inflight_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      beats_left_q <= beats_left_d;
      inflight_q   <= mem_en_c;
      busy_q       <= (state_d == ST_FETCH) | (state_d == ST_DRAIN);
      done_q       <= (state_d == ST_FINISH);
    end
  end

  mem_burst_fifo2 #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push_c),
    .pop_i       (pop_c),
    .flush_i     (flush_c),
    .wdata_i     (mem_rdata),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .occupancy_o (fifo_occ),
    .head_o      (fifo_head)
  );

  logic unused_full;
  assign unused_full = fifo_full;

  assign busy     = busy_q;
  assign done     = done_q;
  assign mem_en   = mem_en_c;
  assign mem_addr = addr_q;
  assign data_out = fifo_head;
  assign valid    = ~fifo_empty;
  assign last     = ~fifo_empty & (beats_left_q == LEN_W'(1));

endmodule

// File: tb/tb_mem_burst_reader.sv
// Directed self-checking bench for mem_burst_reader (ADDR_W=8 to exercise address wrap).
module tb_mem_burst_reader;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned LEN_W  = 10;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]  len;
  logic [ADDR_W-1:0] stride;
  logic              busy;
  logic              done;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] data_out;
  logic              valid;
  logic              ready;
  logic              last;

  mem_burst_reader #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .start_addr (start_addr),
    .len        (len),
    .stride     (stride),
    .busy       (busy),
    .done       (done),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .data_out   (data_out),
    .valid      (valid),
    .ready      (ready),
    .last       (last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {16'hA5A5, a, ~a};
  endfunction

  // One-cycle-latency memory model
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= mem_word(mem_addr);
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;
  int first_en_cyc, first_valid_cyc, done_cyc, last_pop_cyc, abort_cyc;
  int issued, popped;
  bit busy_seen, done_seen;
  logic [7:0] addr_log [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step_edge();
    @(posedge clk);
    #1;
  endtask

  // Runs one burst from the current cycle; abort_at>0 aborts once that many beats are taken.
  task automatic run_burst(input logic [7:0] saddr, input logic [9:0] blen,
                           input logic [7:0] bstride, input int rmode, input int abort_at);
    logic [7:0]  exp_addr, beat_addr, step;
    logic        prev_stall, prev_last;
    logic [31:0] prev_data;
    bit          aborted;
`ifdef MEM_BURST_STRIDE_EN
    step = bstride;
`else
    step = 8'd1;
`endif
    exp_addr = saddr; beat_addr = saddr;
    issued = 0; popped = 0; aborted = 0; abort_cyc = -1;
    first_en_cyc = -1; first_valid_cyc = -1; done_cyc = -1; last_pop_cyc = -1;
    busy_seen = 0; done_seen = 0;
    prev_stall = 0; prev_last = 0; prev_data = '0;

    start = 1; start_addr = saddr; len = blen; stride = bstride; abort = 0;
    ready = (rmode == 0);
    @(negedge clk);
    chk("c0_busy", 32'(busy), 32'd0);
    chk("c0_mem_en", 32'(mem_en), 32'd0);
    step_edge();
    start = 0;

    for (cyc = 1; cyc <= 200 && !done_seen; cyc++) begin
      ready = (rmode == 0) ? 1'b1 : ((cyc % 3) == 1);
      abort = 0;
      if (abort_at > 0 && !aborted && popped == abort_at) begin
        abort = 1; ready = 0; aborted = 1; abort_cyc = cyc;
      end
      @(negedge clk);
      if (busy) busy_seen = 1;
      if (mem_en) begin
        if (first_en_cyc < 0) first_en_cyc = cyc;
        chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
        if (issued < 16) addr_log[issued[3:0]] = mem_addr;
        exp_addr = exp_addr + step;
        issued++;
      end
      if (prev_stall) begin
        chk("stall_valid", 32'(valid), 32'd1);
        chk("stall_data", data_out, prev_data);
        chk("stall_last", 32'(last), 32'(prev_last));
      end
      if (valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (valid && ready) begin
        chk("beat_data", data_out, mem_word(beat_addr));
        chk("beat_last", 32'(last), 32'(popped == int'(blen) - 1));
        beat_addr = beat_addr + step;
        popped++;
        last_pop_cyc = cyc;
      end
      chk("outstanding_le2", 32'(issued - popped <= 2), 32'd1);
      prev_stall = valid && !ready && !abort;
      prev_data  = data_out;
      prev_last  = last;
      if (aborted && cyc == abort_cyc + 1) begin
        chk("abort_valid", 32'(valid), 32'd0);
        chk("abort_done", 32'(done), 32'd1);
      end
      if (aborted && cyc > abort_cyc) chk("abort_no_en", 32'(mem_en), 32'd0);
      if (done) begin
        done_seen = 1;
        done_cyc  = cyc;
        chk("done_busy", 32'(busy), 32'd0);
      end
      step_edge();
    end
    chk("done_seen", 32'(done_seen), 32'd1);
    abort = 0;

    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_no_en", 32'(mem_en), 32'd0);
    step_edge();

    if (abort_at > 0) begin
      chk("abort_beats", 32'(popped), 32'(abort_at));
      chk("abort_done_cyc", 32'(done_cyc), 32'(abort_cyc + 1));
    end else begin
      chk("beats_total", 32'(popped), 32'(blen));
      chk("reads_total", 32'(issued), 32'(blen));
      if (blen != 0) chk("done_after_last", 32'(done_cyc), 32'(last_pop_cyc + 1));
    end
  endtask

  initial begin
    logic [7:0] exp_a;
    rst_n = 0; start = 0; abort = 0; start_addr = '0; len = '0; stride = '0; ready = 0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_data", data_out, 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_last", 32'(last), 32'd0);
    step_edge();
    rst_n = 1;
    step_edge();

    // Basic burst, ready held high
    run_burst(8'h10, 10'd4, 8'd1, 0, 0);
    chk("t1_first_en", 32'(first_en_cyc), 32'd1);
    chk("t1_first_valid", 32'(first_valid_cyc), 32'd3);
    chk("t1_last_beat", 32'(last_pop_cyc), 32'd6);
    chk("t1_done", 32'(done_cyc), 32'd7);
    chk("t1_addr3", 32'(addr_log[3]), 32'h13);

    // Back-pressure: ready 1,0,0 repeating
    run_burst(8'h30, 10'd8, 8'd1, 1, 0);

    // Zero-length burst
    run_burst(8'h44, 10'd0, 8'd1, 0, 0);
    chk("len0_done", 32'(done_cyc), 32'd1);
    chk("len0_busy", 32'(busy_seen), 32'd0);
    chk("len0_valid", 32'(first_valid_cyc), 32'hFFFF_FFFF);

    // Address wrap
    run_burst(8'hFE, 10'd4, 8'd1, 0, 0);
    chk("wrap_a1", 32'(addr_log[1]), 32'hFF);
    chk("wrap_a2", 32'(addr_log[2]), 32'h00);
    chk("wrap_a3", 32'(addr_log[3]), 32'h01);

    // Stride
    run_burst(8'h10, 10'd3, 8'd3, 0, 0);
`ifdef MEM_BURST_STRIDE_EN
    exp_a = 8'h16;
`else
    exp_a = 8'h12;
`endif
    chk("stride_a2", 32'(addr_log[2]), 32'(exp_a));

    // Abort after 2 beats, then a clean follow-up burst
    run_burst(8'h20, 10'd6, 8'd1, 0, 2);
    run_burst(8'h60, 10'd2, 8'd1, 0, 0);

    // Asynchronous reset mid-burst
    start = 1; start_addr = 8'h40; len = 10'd8; stride = 8'd1; ready = 1;
    step_edge();
    start = 0;
    step_edge();
    step_edge();
    step_edge();
    @(negedge clk);
    chk("pre_rst_valid", 32'(valid), 32'd1);
    #1;
    rst_n = 0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_mem_en", 32'(mem_en), 32'd0);
    chk("mid_rst_addr", 32'(mem_addr), 32'd0);
    chk("mid_rst_valid", 32'(valid), 32'd0);
    chk("mid_rst_last", 32'(last), 32'd0);
    chk("mid_rst_data", data_out, 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    step_edge();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
      step_edge();
    end
    run_burst(8'h80, 10'd3, 8'd1, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_burst_reader.md
# mem_burst_reader

Length-bounded, back-pressure-tolerant burst reader between a single-port memory and a valid/ready stream consumer. The memory has one-cycle read latency. It generalises the single-shot burst-out engine with:
- an explicit burst length and an address stride,
- a 2-entry output buffer so throughput is one word per cycle under back-pressure,
- `last`, `done` and abort support.

It sits in Versat memory units wherever a memory block feeds a stream consumer.

## Interface
Parameters:
- DATA_W, 32, data word width
- ADDR_W, 9, memory address width
- LEN_W, 10, burst length counter width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  sample start_addr/len/stride, begin burst
- abort  in  1  terminate active burst, flush buffer
- start_addr  in  ADDR_W  first address
- len  in  LEN_W  number of words in burst
- stride  in  ADDR_W  address increment per word
- busy  out  1  burst in progress
- done  out  1  one-cycle completion pulse
- mem_en  out  1  memory read enable
- mem_addr  out  ADDR_W  memory read address
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en
- data_out  out  DATA_W  stream data
- valid  out  1  stream valid
- ready  in  1  stream ready
- last  out  1  qualifies final beat

## Operation
FSM states:
- IDLE: `start` samples the configuration. If len=0, go to FINISH. Otherwise go to FETCH and set busy.
- FETCH: issue reads until `remaining` = 0, then go to DRAIN.
- DRAIN: wait until the buffer is empty and no read is in flight, then go to FINISH.
- FINISH: done=1 for one cycle, busy=0, return to IDLE.

Read issue rule (FETCH), evaluated in cycle t:
- mem_en=1 iff remaining>0 and (occupancy + inflight − pop_t) < 2.
- pop_t = valid & ready.
- inflight = mem_en of cycle t−1.

Addresses and counters:
- mem_addr starts at start_addr and advances by stride per issued read.
- Address arithmetic is modulo 2^ADDR_W and wraps silently.
- `remaining` is loaded with len and decrements per issued read.
- A separate beat counter tracks handshakes. `last` = valid & (beats_left == 1).

Buffer behaviour:
- mem_rdata is written into the 2-entry FIFO at the end of the cycle following mem_en.
- data_out is the FIFO head. valid = FIFO not empty.
- data is never lost or duplicated; order is preserved.

Boundary conditions:
- `start` while busy is ignored.
- `abort` while busy: FIFO cleared, remaining zeroed, an in-flight read is discarded, valid drops next cycle, go to FINISH (done pulses).
- `abort` in IDLE is ignored.
- `abort` and `start` in the same cycle: abort wins if busy; start wins if idle.
- mem_en is never asserted outside FETCH.

## Timing
- Reset values: busy=0, done=0, mem_en=0, mem_addr=0, data_out=0, valid=0, last=0.
- rst_n low mid-burst clears all state immediately; there is no done pulse.
- Start sampled in cycle 0:
  - first mem_en in cycle 1,
  - first valid in cycle 3,
  - with ready held high, one beat per cycle thereafter.
- Final handshake in cycle N → done in cycle N+1, and busy is low in cycle N+1.
- len=0: done in cycle 1, busy never asserted.
- valid/data_out/last stay stable while valid & !ready.

## Configuration
- MEM_BURST_STRIDE_EN defined: the `stride` port is used as sampled.
- Undefined: the stride increment is fixed at 1; the `stride` port remains present but is ignored and its adder is not synthesised.

## Structure
- Shared package `mem_burst_pkg`:
  - FSM state encoding (IDLE, FETCH, DRAIN, FINISH),
  - FIFO depth constant = 2.
- Sub-module `mem_burst_fifo2`:
  - 2-entry synchronous FIFO, DATA_W wide,
  - ports: push/pop/flush, full/empty, occupancy, head.

## Test plan
- len=4, start_addr=0x10, stride=1, ready=1 → mem_addr 0x10..0x13 in cycles 1–4, beats in cycles 3–6, last in cycle 6, done in cycle 7.
- len=8 with ready toggling 1,0,0,1,… →
  - all 8 words delivered in order,
  - no duplicates,
  - occupancy + inflight ≤ 2 every cycle,
  - data held stable while stalled.
- len=0 → done in cycle 1, no mem_en, no valid.
- ADDR_W=8, start_addr=0xFE, len=4 → mem_addr FE, FF, 00, 01.
- stride=3, start_addr=0x10, len=3 → with macro 0x10, 0x13, 0x16; without macro 0x10, 0x11, 0x12.
- Abort asserted after 2 beats of a len=6 burst →
  - valid low next cycle,
  - done pulse,
  - no further mem_en,
  - a following start with len=2 runs cleanly.
- rst_n pulsed low mid-burst → all outputs 0 immediately, no done pulse.
